fade_sum: RTL and testbench



---
 rtl/fader_pkg.sv | 37 +++
 rtl/cos_rom.sv | 69 ++++++
 rtl/fade_sum.sv | 147 ++++++++++++++
 tb/tb_fade_sum.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fader_pkg.sv
// Shared constants, state encoding and cosine-table generator for the fader
// summation stage.
package fader_pkg;

    localparam int M      = 8;
    localparam int N      = 32;
    localparam int Wpath  = $clog2(M);
    localparam int Wchan  = $clog2(N);
    localparam int Wphase = 14;

    localparam int ROM_DEPTH = 1024;
    localparam int ROM_AW    = 10;
    localparam int ROM_W     = 15;
    localparam int ACC_W     = 16 + Wpath;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_e;

    // One quarter-wave entry: round(32767*cos((k+0.5)*pi/2048)), evaluated at
    // elaboration with a Taylor series so no math library is needed.
    function automatic logic [ROM_W-1:0] cos_quarter_init(input int k);
        real x;
        real term;
        real sum;
        x    = ($itor(k) + 0.5) * 3.14159265358979323846 / 2048.0;
        sum  = 1.0;
        term = 1.0;
        for (int n = 1; n <= 12; n++) begin
            term = -term * x * x / $itor((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        return ROM_W'($rtoi(32767.0 * sum + 0.5));
    endfunction

endpackage

// File: rtl/cos_rom.sv
// Phase-to-cosine lookup through a quarter-wave table; three register stages
// (index, synchronous ROM read, sign) with a valid bit carried alongside.
module cos_rom
    import fader_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic [Wphase-1:0]        phase_in,
    output logic                     valid_out,
    output logic signed [15:0]       cos_out
);

    logic [ROM_W-1:0] rom [ROM_DEPTH];

    for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
        localparam logic [ROM_W-1:0] ENTRY = cos_quarter_init(k);
        assign rom[k] = ENTRY;
    end

    logic                     v1_q, v2_q, v3_q;
    logic                     neg1_d, neg1_q, neg2_q;
    logic [ROM_AW-1:0]        idx1_d, idx1_q;
    logic [ROM_W-1:0]         rom_d, rom_q;
    logic signed [15:0]       cos_d, cos_q;
    logic                     unused_phase_lsb;

    assign unused_phase_lsb = ^phase_in[1:0];

    // Quadrants 1 and 3 read the mirrored index; quadrants 1 and 2 negate.
    always_comb begin
        neg1_d = phase_in[Wphase-1] ^ phase_in[Wphase-2];
        idx1_d = phase_in[Wphase-2] ? ~phase_in[Wphase-3:2] : phase_in[Wphase-3:2];
        rom_d  = rom[idx1_q];
        cos_d  = neg2_q ? -$signed({1'b0, rom_q}) : $signed({1'b0, rom_q});
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's pre-edge value, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            neg1_q <= 1'b0;
            neg2_q <= 1'b0;
            idx1_q <= '0;
            cos_q  <= '0;
        end else begin
            v1_q   <= valid_in;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
            neg1_q <= neg1_d;
            neg2_q <= neg1_q;
            idx1_q <= idx1_d;
            cos_q  <= cos_d;
        end
    end

    // NOTE: the ROM data register has no reset so it maps onto a block RAM
    // output register; its contents are qualified by v2_q anyway.
    always_ff @(posedge clk) begin
        rom_q <= rom_d;
    end

    assign valid_out = v3_q;
    assign cos_out   = cos_q;

endmodule

// File: rtl/fade_sum.sv
// Sums the M cosine-mapped paths of each channel into one complex fading
// coefficient, checking the M-1..0 path order as it goes.
module fade_sum
    import fader_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dv_in,
    input  logic [Wchan-1:0]         chan_in,
    input  logic [Wpath-1:0]         path_in,
    input  logic [Wphase-1:0]        arg_real,
    input  logic [Wphase-1:0]        arg_imag,
    output logic                     dv_out,
    output logic [Wchan-1:0]         chan_out,
    output logic signed [15:0]       Zc_real,
    output logic signed [15:0]       Zc_imag,
    output logic                     seq_err
);

    localparam logic [Wpath-1:0] LAST_PATH = Wpath'(M - 1);
    localparam logic [Wpath-1:0] NEXT_PATH = Wpath'(M - 2);

    logic                     v3_re, v3_im, v3;
    logic signed [15:0]       cos_re, cos_im;

    cos_rom u_cos_re (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (dv_in),
        .phase_in  (arg_real),
        .valid_out (v3_re),
        .cos_out   (cos_re)
    );

    cos_rom u_cos_im (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (dv_in),
        .phase_in  (arg_imag),
        .valid_out (v3_im),
        .cos_out   (cos_im)
    );

    assign v3 = v3_re & v3_im;

    // Path and channel ride alongside the cosine pipe; index 2 lines up with v3.
    logic [2:0][Wpath-1:0]    path_p_d, path_p_q;
    logic [2:0][Wchan-1:0]    chan_p_d, chan_p_q;

    state_e                   state_d, state_q;
    logic [Wpath-1:0]         exp_d, exp_q;
    logic [Wchan-1:0]         chan_cur_d, chan_cur_q;
    logic signed [ACC_W-1:0]  acc_re_d, acc_re_q, acc_im_d, acc_im_q;
    logic signed [ACC_W-1:0]  ext_re, ext_im;
    logic                     done_d, done_q;
    logic                     seq_err_d, seq_err_q;
    logic                     dv_out_d, dv_out_q;
    logic [Wchan-1:0]         chan_out_d, chan_out_q;
    logic signed [15:0]       zc_re_d, zc_re_q, zc_im_d, zc_im_q;
    logic                     opens;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        path_p_d   = {path_p_q[1:0], path_in};
        chan_p_d   = {chan_p_q[1:0], chan_in};
        state_d    = state_q;
        exp_d      = exp_q;
        chan_cur_d = chan_cur_q;
        acc_re_d   = acc_re_q;
        acc_im_d   = acc_im_q;
        done_d     = 1'b0;
        seq_err_d  = 1'b0;
        ext_re     = {{Wpath{cos_re[15]}}, cos_re};
        ext_im     = {{Wpath{cos_im[15]}}, cos_im};
        opens      = (path_p_q[2] == LAST_PATH);

        if (v3) begin
            if (state_q == ACCUM && path_p_q[2] == exp_q && chan_p_q[2] == chan_cur_q) begin
                acc_re_d = acc_re_q + ext_re;
                acc_im_d = acc_im_q + ext_im;
                if (path_p_q[2] == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    exp_d = exp_q - 1'b1;
                end
            end else begin
                // An M-1 sample opens a channel; it is only an error if one was open.
                seq_err_d = (state_q == ACCUM) || !opens;
                if (opens) begin
                    acc_re_d   = ext_re;
                    acc_im_d   = ext_im;
                    exp_d      = NEXT_PATH;
                    chan_cur_d = chan_p_q[2];
                    state_d    = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
        end

        dv_out_d   = done_q;
        chan_out_d = done_q ? chan_cur_q : chan_out_q;
        zc_re_d    = done_q ? acc_re_q[ACC_W-1:Wpath] : zc_re_q;
        zc_im_d    = done_q ? acc_im_q[ACC_W-1:Wpath] : zc_im_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            path_p_q   <= '0;
            chan_p_q   <= '0;
            state_q    <= IDLE;
            exp_q      <= '0;
            chan_cur_q <= '0;
            acc_re_q   <= '0;
            acc_im_q   <= '0;
            done_q     <= 1'b0;
            seq_err_q  <= 1'b0;
            dv_out_q   <= 1'b0;
            chan_out_q <= '0;
            zc_re_q    <= '0;
            zc_im_q    <= '0;
        end else begin
            path_p_q   <= path_p_d;
            chan_p_q   <= chan_p_d;
            state_q    <= state_d;
            exp_q      <= exp_d;
            chan_cur_q <= chan_cur_d;
            acc_re_q   <= acc_re_d;
            acc_im_q   <= acc_im_d;
            done_q     <= done_d;
            seq_err_q  <= seq_err_d;
            dv_out_q   <= dv_out_d;
            chan_out_q <= chan_out_d;
            zc_re_q    <= zc_re_d;
            zc_im_q    <= zc_im_d;
        end
    end

    assign dv_out   = dv_out_q;
    assign chan_out = chan_out_q;
    assign Zc_real  = zc_re_q;
    assign Zc_imag  = zc_im_q;
    assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_fade_sum.sv
// Scoreboard bench for fade_sum: expected coefficients are queued as stimulus
// is driven and popped when dv_out fires; a second cos_rom is swept directly.
module tb_fade_sum;
    import fader_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                dv_in;
    logic [Wchan-1:0]    chan_in;
    logic [Wpath-1:0]    path_in;
    logic [Wphase-1:0]   arg_real, arg_imag;
    logic                dv_out;
    logic [Wchan-1:0]    chan_out;
    logic signed [15:0]  Zc_real, Zc_imag;
    logic                seq_err;

    logic                rv_in, rv_out;
    logic [Wphase-1:0]   rph;
    logic signed [15:0]  rcos;

    always #5 clk = ~clk;

    fade_sum dut (
        .clk      (clk),
        .reset    (reset),
        .dv_in    (dv_in),
        .chan_in  (chan_in),
        .path_in  (path_in),
        .arg_real (arg_real),
        .arg_imag (arg_imag),
        .dv_out   (dv_out),
        .chan_out (chan_out),
        .Zc_real  (Zc_real),
        .Zc_imag  (Zc_imag),
        .seq_err  (seq_err)
    );

    cos_rom rom_u (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (rv_in),
        .phase_in  (rph),
        .valid_out (rv_out),
        .cos_out   (rcos)
    );

    typedef struct {
        int chan;
        int re;
        int im;
    } exp_t;

    exp_t           sb[$];
    int             rom_sb[$];
    int             dv_cyc_q[$];
    int             n_vec = 0;
    int             n_err = 0;
    int             tbl[1024];
    int             cyc = 0;
    int             dv_cnt = 0;
    int             seq_cnt = 0;
    int             last_dv_cyc = 0;
    int             last_seq_cyc = 0;
    int             last_drive_cyc = 0;
    logic [13:0]    ph_re[8];
    logic [13:0]    ph_im[8];

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_cos(input logic [13:0] ph);
        logic [1:0] q;
        logic [9:0] i;
        logic [9:0] ni;
        q  = ph[13:12];
        i  = ph[11:2];
        ni = ~i;
        case (q)
            2'd0:    return tbl[i];
            2'd1:    return -tbl[ni];
            2'd2:    return -tbl[i];
            default: return tbl[ni];
        endcase
    endfunction

    function automatic void push_channel(input int ch);
        int sr = 0;
        int si = 0;
        for (int p = 0; p < 8; p++) begin
            sr += model_cos(ph_re[p]);
            si += model_cos(ph_im[p]);
        end
        sb.push_back('{ch, sr >>> 3, si >>> 3});
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (dv_out) begin
            dv_cnt++;
            last_dv_cyc = cyc;
            dv_cyc_q.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_dv_out", 1, 0);
            end else begin
                e = sb.pop_front();
                check("chan_out", chan_out, e.chan);
                check("Zc_real", Zc_real, e.re);
                check("Zc_imag", Zc_imag, e.im);
            end
        end
        if (seq_err) begin
            seq_cnt++;
            last_seq_cyc = cyc;
        end
        if (rv_out) begin
            if (rom_sb.size() == 0) check("rom_unexpected_valid", 1, 0);
            else check("rom_cos", rcos, rom_sb.pop_front());
        end
    end

    task automatic send_sample(input int ch, input int p, input logic [13:0] re, input logic [13:0] im);
        dv_in    = 1'b1;
        chan_in  = Wchan'(ch);
        path_in  = Wpath'(p);
        arg_real = re;
        arg_imag = im;
        last_drive_cyc = cyc;
        @(posedge clk);
        #1;
        dv_in = 1'b0;
    endtask

    task automatic idle(input int n);
        dv_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic maybe_gap(input bit gaps);
        if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    endtask

    task automatic send_channel(input int ch, input bit gaps);
        push_channel(ch);
        for (int p = 7; p >= 0; p--) begin
            maybe_gap(gaps);
            send_sample(ch, p, ph_re[p], ph_im[p]);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || rom_sb.size() != 0) && n < 40) begin
            @(posedge clk);
            n++;
        end
        repeat (8) @(posedge clk);
        #1;
        check("drain_sb", sb.size(), 0);
    endtask

    task automatic randomize_phases();
        for (int p = 0; p < 8; p++) begin
            ph_re[p] = 14'($urandom);
            ph_im[p] = 14'($urandom);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dv_out"}, dv_out, 0);
        check({tag, "_seq_err"}, seq_err, 0);
        check({tag, "_chan_out"}, chan_out, 0);
        check({tag, "_Zc_real"}, Zc_real, 0);
        check({tag, "_Zc_imag"}, Zc_imag, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int off_cyc;
        int dv_base;
        int seq_base;

        for (int k = 0; k < 1024; k++)
            tbl[k] = $rtoi(32767.0 * $cos(($itor(k) + 0.5) * 3.14159265358979323846 / 2048.0) + 0.5);

        reset = 1'b0; dv_in = 1'b0; chan_in = '0; path_in = '0;
        arg_real = '0; arg_imag = '0; rv_in = 1'b0; rph = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Channel 5: full-scale positive real, full-scale negative imaginary
        for (int p = 0; p < 8; p++) begin ph_re[p] = 14'h0000; ph_im[p] = 14'h2000; end
        send_channel(5, 1'b0);
        p0 = last_drive_cyc;
        drain();
        check("t1_latency", last_dv_cyc - p0, 5);
        check("t1_dv_count", dv_cnt, 1);
        check("t1_chan", chan_out, 5);
        check("t1_re", Zc_real, 32767);
        check("t1_im", Zc_imag, -32767);

        // Channel 0 at +-pi/2: smallest table entry
        for (int p = 0; p < 8; p++) begin ph_re[p] = 14'h1000; ph_im[p] = 14'h3000; end
        send_channel(0, 1'b0);
        drain();
        check("t2_chan", chan_out, 0);
        check("t2_re", Zc_real, -25);
        check("t2_im", Zc_imag, 25);

        // Interleaved opposite phases cancel
        for (int p = 0; p < 8; p++) begin
            ph_re[p] = (p % 2) ? 14'h2000 : 14'h0000;
            ph_im[p] = (p % 2) ? 14'h0000 : 14'h2000;
        end
        send_channel(3, 1'b0);
        drain();
        check("t3_re", Zc_real, 0);
        check("t3_im", Zc_imag, 0);

        // Every 4th phase code through a standalone cos_rom
        for (int k = 0; k < 4096; k++) begin
            rv_in = 1'b1;
            rph   = 14'(k * 4);
            rom_sb.push_back(model_cos(rph));
            @(posedge clk); #1;
        end
        rv_in = 1'b0;
        drain();
        check("rom_drain", rom_sb.size(), 0);

        // 32 channels back to back, random phases
        dv_cyc_q.delete();
        dv_base = dv_cnt;
        for (int ch = 31; ch >= 0; ch--) begin
            randomize_phases();
            send_channel(ch, 1'b0);
        end
        drain();
        check("b2b_count", dv_cnt - dv_base, 32);
        for (int i = 1; i < dv_cyc_q.size(); i++)
            check("b2b_spacing", dv_cyc_q[i] - dv_cyc_q[i-1], 8);

        // Aborted 7,6,5 then complete 7..0, without and with gaps
        randomize_phases();
        for (int rep = 0; rep < 2; rep++) begin
            dv_base  = dv_cnt;
            seq_base = seq_cnt;
            for (int p = 7; p >= 5; p--) begin
                maybe_gap(rep == 1);
                send_sample(9, p, ph_re[p], ph_im[p]);
            end
            push_channel(9);
            maybe_gap(rep == 1);
            send_sample(9, 7, ph_re[7], ph_im[7]);
            off_cyc = last_drive_cyc;
            for (int p = 6; p >= 0; p--) begin
                maybe_gap(rep == 1);
                send_sample(9, p, ph_re[p], ph_im[p]);
            end
            drain();
            check("seq_err_count", seq_cnt - seq_base, 1);
            check("seq_err_latency", last_seq_cyc - off_cyc, 4);
            check("seq_dv_count", dv_cnt - dv_base, 1);
        end

        // Stray path while idle is dropped
        dv_base  = dv_cnt;
        seq_base = seq_cnt;
        send_sample(2, 3, 14'h0000, 14'h0000);
        drain();
        check("idle_stray_seq", seq_cnt - seq_base, 1);
        check("idle_stray_dv", dv_cnt - dv_base, 0);

        // Channel number changes mid-channel
        dv_base  = dv_cnt;
        seq_base = seq_cnt;
        send_sample(4, 7, 14'h0000, 14'h0000);
        send_sample(4, 6, 14'h0000, 14'h0000);
        send_sample(6, 5, 14'h0000, 14'h0000);
        drain();
        check("chan_change_seq", seq_cnt - seq_base, 1);
        check("chan_change_dv", dv_cnt - dv_base, 0);

        // Reset after path 3 of a channel
        randomize_phases();
        dv_base  = dv_cnt;
        seq_base = seq_cnt;
        for (int p = 7; p >= 3; p--) send_sample(12, p, ph_re[p], ph_im[p]);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        repeat (2) @(posedge clk); #1;
        reset = 1'b1;
        idle(8);
        check("abort_dv", dv_cnt - dv_base, 0);
        check("abort_seq", seq_cnt - seq_base, 0);
        send_channel(12, 1'b0);
        drain();
        check("after_reset_dv", dv_cnt - dv_base, 1);
        check("after_reset_chan", chan_out, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
